// File: rtl/add_sub_stage.sv
// Two-stage add/sub pipeline (operand stage, result stage) driving an external 32-bit adder.
// Define ADD_SUB_FLAGS_EN to build N/Z/C/V flags and the carry register used by ADC/SBB.
module add_sub_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_t;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_t              s1_op;
  logic             s2_valid;
  logic             s1_adv;
  logic             in_xfer;

  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s1_adv;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;

`ifdef ADD_SUB_FLAGS_EN
  logic carry_reg;
`endif

  // Adder operands are forced to zero whenever S1 is empty.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (s1_valid) begin
      add_a = s1_a;
      add_b = (s1_op == OP_SUB || s1_op == OP_SBB) ? ~s1_b : s1_b;
      unique case (s1_op)
        OP_ADD: add_cin = 1'b0;
        OP_SUB: add_cin = 1'b1;
`ifdef ADD_SUB_FLAGS_EN
        OP_ADC: add_cin = carry_reg;
        OP_SBB: add_cin = ~carry_reg;
`else
        OP_ADC: add_cin = 1'b0;
        OP_SBB: add_cin = 1'b1;
`endif
        default: add_cin = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= op_t'(in_op);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
    end else if (s1_adv) begin
      s2_valid   <= 1'b1;
      out_result <= add_sum;
    end else if (out_ready) begin
      s2_valid   <= 1'b0;
    end
  end

`ifdef ADD_SUB_FLAGS_EN
  logic [3:0] flags_next;

  always_comb begin
    flags_next    = '0;
    flags_next[3] = add_sum[WIDTH-1];
    flags_next[2] = (add_sum == '0);
    flags_next[1] = add_cout;
    flags_next[0] = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != add_a[WIDTH-1]);
  end

  // carry_reg follows every advancing result so a back-to-back ADC/SBB sees it next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_flags <= '0;
      carry_reg <= 1'b0;
    end else if (s1_adv) begin
      out_flags <= flags_next;
      carry_reg <= add_cout;
    end
  end
`else
  logic unused_cout;
  assign unused_cout = add_cout;
  assign out_flags   = '0;
`endif

endmodule

// File: tb/tb_add_sub_stage.sv
// Scoreboard bench for add_sub_stage with a behavioural model of the external adder.
// Follows ADD_SUB_FLAGS_EN the same way as the design build.
module tb_add_sub_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  always #5 clk = ~clk;

  add_sub_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  logic m_carry;
  int   vectors;
  int   miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [31:0] bb;
    logic        cin;
    logic [32:0] full;
    exp_t        e;
    bb = op[0] ? ~b : b;
    case (op)
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
`ifdef ADD_SUB_FLAGS_EN
      2'b10:   cin = m_carry;
      default: cin = ~m_carry;
`else
      2'b10:   cin = 1'b0;
      default: cin = 1'b1;
`endif
    endcase
    full  = {1'b0, a} + {1'b0, bb} + {32'b0, cin};
    e.res = full[31:0];
`ifdef ADD_SUB_FLAGS_EN
    e.flg   = {full[31], (full[31:0] == 32'd0), full[32],
               (a[31] == bb[31]) && (full[31] != a[31])};
    m_carry = full[32];
`else
    e.flg = 4'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb[0];
        check(out_ready ? "result" : "hold_result", out_result, e.res);
        check(out_ready ? "flags" : "hold_flags", {28'd0, out_flags}, {28'd0, e.flg});
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (acc) push_model(a, b, op);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 32'd0, 32'd0, 2'b00, ordy, acc);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, a, b, op, 1'b1, acc);
    if (!acc) check("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) idle(1'b1);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          idx;
    logic [31:0] sa [4];
    logic [31:0] sbv[4];
    logic [1:0]  sop[4];

    vectors = 0; miscompares = 0; m_carry = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",   {31'd0, in_ready},  32'd1);
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result,         32'd0);
    check("rst_out_flags",  {28'd0, out_flags}, 32'd0);
    check("idle_add_a",     add_a,              32'd0);
    check("idle_add_b",     add_b,              32'd0);
    check("idle_add_cin",   {31'd0, add_cin},   32'd0);

    // ADD wraps to zero; out_valid appears exactly two cycles after acceptance
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, acc);
    check("first_accept", {31'd0, acc}, 32'd1);
    idle(1'b1);
    check("latency_s1_only", {31'd0, out_valid}, 32'd0);
    check("s1_add_a", add_a, 32'hFFFF_FFFF);
    idle(1'b1);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // ADD then back-to-back ADC consuming its carry
    send(32'h0000_0001, 32'hFFFF_FFFF, 2'b00);
    send(32'h0000_0000, 32'h0000_0000, 2'b10);
    idle(1'b1);
    idle(1'b1);
    check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // SUB overflow and borrow cases, then SBB after a borrow
    send(32'h8000_0000, 32'h0000_0001, 2'b01);
    send(32'h0000_0000, 32'h0000_0001, 2'b01);
    send(32'h0000_0005, 32'h0000_0002, 2'b11);
    send(32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
    drain();

    // Stall: 4 ops offered while out_ready is held low for 5 cycles
    sa[0] = 32'h0000_0010; sbv[0] = 32'h0000_0020; sop[0] = 2'b00;
    sa[1] = 32'h0000_0100; sbv[1] = 32'h0000_0001; sop[1] = 2'b01;
    sa[2] = 32'hFFFF_FFFF; sbv[2] = 32'hFFFF_FFFF; sop[2] = 2'b00;
    sa[3] = 32'h0000_0003; sbv[3] = 32'h0000_0004; sop[3] = 2'b10;
    idx = 0;
    for (int t = 0; t < 5; t++) begin
      step(idx < 4, sa[idx % 4], sbv[idx % 4], sop[idx % 4], 1'b0, acc);
      if (acc) idx++;
      if (t >= 2) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check("stall_accepts", 32'(idx), 32'd2);
    for (int t = 0; t < 4; t++) begin
      step(idx < 4, sa[idx % 4], sbv[idx % 4], sop[idx % 4], 1'b1, acc);
      if (acc) idx++;
      check("no_gap_valid", {31'd0, out_valid}, 32'd1);
    end
    check("stream_accepts", 32'(idx), 32'd4);
    drain();

    // Reset with both stages full discards everything
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 2'b00, 1'b0, acc);
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 2'b00, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("midrst_out_flags",  {28'd0, out_flags}, 32'd0);
    check("midrst_out_result", out_result,         32'd0);
    check("midrst_in_ready",   {31'd0, in_ready},  32'd1);
    sb.delete();
    m_carry = 1'b0;
    rst_n = 1'b1;
    repeat (3) idle(1'b1);
    check("post_reset_idle", {31'd0, out_valid}, 32'd0);

    send(32'h0000_0001, 32'hFFFF_FFFF, 2'b00);
    send(32'h0000_0000, 32'h0000_0000, 2'b10);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      step($urandom_range(0, 3) != 0, ra, rb, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_sub_stage.md
ADD_SUB_STAGE -- requirements
Module: add_sub_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-004 SHALL have port in_valid, input, 1, upstream operands valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-006 SHALL have port in_a, input, 32, operand A.
REQ-007 SHALL have port in_b, input, 32, operand B.
REQ-008 SHALL have port in_op, input, 2, operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-009 SHALL have port add_a, output, 32, A operand driven to the external 32-bit ripple adder.
REQ-010 SHALL have port add_b, output, 32, effective B operand driven to the adder.
REQ-011 SHALL have port add_cin, output, 1, carry-in driven to the adder.
REQ-012 SHALL have port add_sum, input, 32, adder sum return.
REQ-013 SHALL have port add_cout, input, 1, adder carry-out return.
REQ-014 SHALL have port out_valid, output, 1, result valid.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-016 SHALL have port out_result, output, 32, registered sum.
REQ-017 SHALL have port out_flags, output, 4, {N,Z,C,V} of out_result.

Function
REQ-018 SHALL be a two-stage pipeline: S1 holds operands/op; S2 holds result/flags. Each stage has a valid bit.
REQ-019 Transfer occurs when valid and ready are both high on a rising clk; in_a/in_b/in_op are sampled only on a transfer.
REQ-020 in_ready SHALL equal !s1_valid || s1_adv, where s1_adv = s1_valid && (!s2_valid || out_ready).
REQ-021 While s1_valid, add_a = S1.a. add_b = S1.b for ADD/ADC and ~S1.b for SUB/SBB. add_cin = 0 for ADD, 1 for SUB, carry_reg for ADC, ~carry_reg for SBB. When !s1_valid, all three SHALL be 0.
REQ-022 On s1_adv, S2 SHALL capture add_sum into out_result and compute N = sum[31], Z = (sum == 0), C = add_cout, V = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]).
REQ-023 carry_reg SHALL update to C on every s1_adv. For SUB/SBB, C = 1 means no borrow.
REQ-024 Latency from an accepted input to out_valid SHALL be exactly 2 cycles with no stall. Throughput SHALL be 1 result per cycle while out_ready = 1.
REQ-025 While out_valid && !out_ready, out_result and out_flags SHALL hold stable. S1 SHALL hold, and in_ready SHALL drop once S1 is full.
REQ-026 Back-to-back ADC after ADD SHALL use the carry of the immediately preceding result; no extra cycle is inserted.
REQ-027 Simultaneous S2 drain and S1 advance SHALL occur in the same cycle without a bubble.
REQ-028 Results SHALL emerge in acceptance order. No result is dropped or duplicated.

Reset
REQ-029 When rst_n = 0 at a clk edge, s1_valid, s2_valid, carry_reg, out_result and out_flags SHALL clear to 0. in_ready SHALL be 1 in the first cycle after reset release.
REQ-030 Reset mid-operation SHALL discard in-flight operations. No out_valid SHALL assert until a new input is accepted.

Configuration
REQ-031 Macro ADD_SUB_FLAGS_EN defined: N/Z/C/V and carry_reg are implemented as in REQ-021 to REQ-023.
REQ-032 Macro ADD_SUB_FLAGS_EN undefined: out_flags SHALL be constant 0 and carry_reg SHALL not exist. ADC SHALL behave as ADD and SBB as SUB; ports are unchanged.

Verification
REQ-033 Reset, then ADD A=0xFFFFFFFF, B=0x00000001 -> 2 cycles later out_result=0x00000000, flags N0 Z1 C1 V0.
REQ-034 ADD 0x00000001+0xFFFFFFFF, then ADC 0x00000000+0x00000000 back-to-back -> results 0x00000000 and 0x00000001 on consecutive cycles.
REQ-035 SUB 0x80000000-0x00000001 -> out_result=0x7FFFFFFF, flags N0 Z0 C1 V1; SUB 0x00000000-0x00000001 -> out_result=0xFFFFFFFF, C0.
REQ-036 Stream 4 ops, hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, out_result stable. Release -> all 4 results in order, no gaps.
REQ-037 Assert rst_n=0 with both stages full -> next cycle out_valid=0, out_flags=0, in_ready=1. With ADD_SUB_FLAGS_EN undefined, the REQ-034 sequence yields 0x00000000 then 0x00000000.
